// File: rtl/psum_arb_pkg.sv
// Shared definitions for the psum scratchpad arbiter: FSM encodings,
// requester identifiers and an address range helper.
// No ports; imported by the arbiter top and the valid table.
package psum_arb_pkg;

  // Arbiter FSM states. The encodings are fixed so debug views of the state
  // register stay stable.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_WR = 2'd1,
    DRN_RD = 2'd2
  } arb_state_e;

  // Requester identifiers, used when reporting or tracing grants.
  typedef enum logic [1:0] {
    REQ_MAC = 2'd0,
    REQ_ADD = 2'd1,
    REQ_DRN = 2'd2
  } req_id_e;

  // True when addr names a real scratchpad entry. The address field can be
  // wider than the table when the depth is not a power of two.
  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/psum_scratch_arbiter_if.sv
// Request, drain-output and scratchpad-port bundle for psum_scratch_arbiter.
// slave: arbiter side (takes requests and read data, drives readys, output and sp port).
// master: environment side (requesters, drain consumer, scratchpad).
interface psum_scratch_arbiter_if #(
  parameter int SCRATCH_WIDTH = 16,
  parameter int ADDR_LEN      = 4
);
  // MAC writeback accumulate
  logic                     mac_valid;
  logic [ADDR_LEN-1:0]      mac_addr;
  logic [SCRATCH_WIDTH-1:0] mac_data;
  logic                     mac_ready;
  // External "just add" accumulate
  logic                     add_valid;
  logic [ADDR_LEN-1:0]      add_addr;
  logic [SCRATCH_WIDTH-1:0] add_data;
  logic                     add_ready;
  // Drain request and drained value
  logic                     drn_valid;
  logic [ADDR_LEN-1:0]      drn_addr;
  logic                     drn_ready;
  logic [SCRATCH_WIDTH-1:0] out_data;
  logic                     out_valid;
  // Single-port scratchpad
  logic [ADDR_LEN-1:0]      sp_addr;
  logic                     sp_wen;
  logic [SCRATCH_WIDTH-1:0] sp_wdata;
  logic [SCRATCH_WIDTH-1:0] sp_rdata;

  modport slave (
    input  mac_valid, mac_addr, mac_data,
    input  add_valid, add_addr, add_data,
    input  drn_valid, drn_addr,
    input  sp_rdata,
    output mac_ready, add_ready, drn_ready,
    output out_data, out_valid,
    output sp_addr, sp_wen, sp_wdata
  );

  modport master (
    output mac_valid, mac_addr, mac_data,
    output add_valid, add_addr, add_data,
    output drn_valid, drn_addr,
    output sp_rdata,
    input  mac_ready, add_ready, drn_ready,
    input  out_data, out_valid,
    input  sp_addr, sp_wen, sp_wdata
  );

endinterface

// File: rtl/psum_valid_table.sv
// Per-entry valid bits for the psum scratchpad; rd_bit is a combinational read.
// Ports: clk/rst; set_en/set_addr, clr_en/clr_addr, clear_all (wins over both);
// rd_addr -> rd_bit. Out-of-range addresses never set and always read 0.
module psum_valid_table
  import psum_arb_pkg::*;
#(
  parameter int SCRATCH_DEPTH = 16,
  parameter int ADDR_LEN      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_LEN-1:0] set_addr,
  input  logic                clr_en,
  input  logic [ADDR_LEN-1:0] clr_addr,
  input  logic                clear_all,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic                rd_bit
);

  logic [SCRATCH_DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clear_all) begin
      valid_d = '0;
    end else begin
      if (set_en && addr_in_range(32'(set_addr), SCRATCH_DEPTH)) begin
        valid_d[set_addr] = 1'b1;
      end
      if (clr_en && addr_in_range(32'(clr_addr), SCRATCH_DEPTH)) begin
        valid_d[clr_addr] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_bit = addr_in_range(32'(rd_addr), SCRATCH_DEPTH) ? valid_q[rd_addr] : 1'b0;

endmodule

// File: rtl/psum_scratch_arbiter.sv
// Arbitrates the single-port psum scratchpad between MAC writeback, the external
// accumulate path and the drain. Ports: clk, rst, clear, busy, plus the bus
// bundle (requests/readys, drained output, scratchpad port). One op per 2 cycles.
module psum_scratch_arbiter
  import psum_arb_pkg::*;
#(
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 16,
  parameter int ADDR_LEN      = 4   // must equal $clog2(SCRATCH_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  psum_scratch_arbiter_if.slave  bus,
  output logic                   busy
);

  arb_state_e               state_q, state_d;
  logic [ADDR_LEN-1:0]      addr_q, addr_d;
  logic [SCRATCH_WIDTH-1:0] data_q, data_d;
  // 0: MAC wins a MAC/ADD tie, 1: ADD wins
  logic                     rr_add_q, rr_add_d;
  logic [SCRATCH_WIDTH-1:0] out_data_q;

  logic                     mac_rdy, add_rdy, drn_rdy;
  logic [ADDR_LEN-1:0]      sp_addr;
  logic                     sp_wen;
  logic [SCRATCH_WIDTH-1:0] sp_wdata;
  logic                     out_vld;
  logic [SCRATCH_WIDTH-1:0] drn_val;
  logic                     set_en, clr_en, vbit;

  psum_valid_table #(
    .SCRATCH_DEPTH (SCRATCH_DEPTH),
    .ADDR_LEN      (ADDR_LEN)
  ) u_valid (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_addr  (addr_q),
    .clr_en    (clr_en),
    .clr_addr  (addr_q),
    .clear_all (clear),
    .rd_addr   (addr_q),
    .rd_bit    (vbit)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rr_add_d = rr_add_q;
    mac_rdy  = 1'b0;
    add_rdy  = 1'b0;
    drn_rdy  = 1'b0;
    sp_addr  = '0;
    sp_wen   = 1'b0;
    sp_wdata = '0;
    out_vld  = 1'b0;
    drn_val  = '0;
    set_en   = 1'b0;
    clr_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The grant path is combinational from the request inputs, so it is
        // gated by rst as well to keep every output low while reset is held.
        if (!rst && !clear) begin
          if (bus.drn_valid) begin
            drn_rdy = 1'b1;
            sp_addr = bus.drn_addr;
            addr_d  = bus.drn_addr;
            state_d = DRN_RD;
          end else if (bus.mac_valid && (!bus.add_valid || !rr_add_q)) begin
            mac_rdy  = 1'b1;
            sp_addr  = bus.mac_addr;
            addr_d   = bus.mac_addr;
            data_d   = bus.mac_data;
            rr_add_d = 1'b1;
            state_d  = ACC_WR;
          end else if (bus.add_valid) begin
            add_rdy  = 1'b1;
            sp_addr  = bus.add_addr;
            addr_d   = bus.add_addr;
            data_d   = bus.add_data;
            rr_add_d = 1'b0;
            state_d  = ACC_WR;
          end
        end
      end
      ACC_WR: begin
        // Read data for addr_q arrives this cycle; an invalid entry is treated
        // as zero so stale memory contents never leak into the sum.
        sp_addr  = addr_q;
        sp_wen   = 1'b1;
        sp_wdata = vbit ? (bus.sp_rdata + data_q) : data_q;
        set_en   = 1'b1;   // overridden by clear inside the valid table
        state_d  = IDLE;
      end
      DRN_RD: begin
        sp_addr = addr_q;
        drn_val = vbit ? bus.sp_rdata : '0;
        out_vld = !clear;
        clr_en  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rr_add_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rr_add_q <= rr_add_d;
      if (out_vld) begin
        out_data_q <= drn_val;
      end
    end
  end

  assign bus.mac_ready = mac_rdy;
  assign bus.add_ready = add_rdy;
  assign bus.drn_ready = drn_rdy;
  assign bus.sp_addr   = sp_addr;
  assign bus.sp_wen    = sp_wen;
  assign bus.sp_wdata  = sp_wdata;
  assign bus.out_valid = out_vld;
  // Drained value shows in its own cycle, then holds until the next drain.
  assign bus.out_data  = out_vld ? drn_val : out_data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_psum_scratch_arbiter.sv
module tb_psum_scratch_arbiter;
  import psum_arb_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = 16;
  localparam int AL    = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic clear = 1'b0;
  logic busy;

  psum_scratch_arbiter_if #(.SCRATCH_WIDTH(W), .ADDR_LEN(AL)) bus ();

  psum_scratch_arbiter #(
    .SCRATCH_DEPTH (DEPTH),
    .SCRATCH_WIDTH (W),
    .ADDR_LEN      (AL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Scratchpad model: 1-cycle read latency, preloaded with junk so that the
  // valid-bit masking is exercised on the first write of every entry.
  logic [W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hDE00 + 16'(i);
  end
  always @(posedge clk) begin
    if (bus.sp_wen) mem[bus.sp_addr] <= bus.sp_wdata;
    bus.sp_rdata <= mem[bus.sp_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { req_id_e id; int gap; } grant_t;
  typedef struct { logic [AL-1:0] addr; logic [W-1:0] data; } wr_t;
  grant_t       gq[$];
  wr_t          wq[$];
  logic [W-1:0] oq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a grant, a write
  // or a drained value; also checks the idle-value rules every cycle.
  int           last_gnt = -100;
  logic [W-1:0] held = '0;
  int           nr;
  req_id_e      mid;
  grant_t       ge;
  wr_t          we;
  logic [W-1:0] oe;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      held = '0;
    end else begin
      nr = int'(bus.mac_ready) + int'(bus.add_ready) + int'(bus.drn_ready);
      if (nr > 1) begin
        check("single_ready", 32'(nr), 32'd1);
      end else if (nr == 1) begin
        mid = bus.drn_ready ? REQ_DRN : (bus.add_ready ? REQ_ADD : REQ_MAC);
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'(mid), 32'hFFFF);
        end else begin
          ge = gq.pop_front();
          check("grant_id", 32'(mid), 32'(ge.id));
          if (ge.gap > 0) check("grant_gap", 32'(cyc - last_gnt), 32'(ge.gap));
        end
        last_gnt = cyc;
      end
      if (bus.sp_wen) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(bus.sp_addr), 32'hFFFF);
        end else begin
          we = wq.pop_front();
          check("wr_addr", 32'(bus.sp_addr), 32'(we.addr));
          check("wr_data", 32'(bus.sp_wdata), 32'(we.data));
        end
      end else begin
        check("wdata_zero_no_wen", 32'(bus.sp_wdata), 32'd0);
      end
      if (bus.out_valid) begin
        if (oq.size() == 0) begin
          check("unexpected_out", 32'(bus.out_data), 32'hFFFF);
        end else begin
          oe = oq.pop_front();
          check("out_data", 32'(bus.out_data), 32'(oe));
          held = oe;
        end
      end else begin
        check("out_hold", 32'(bus.out_data), 32'(held));
      end
    end
  end

  function automatic logic ready_of(input req_id_e id);
    case (id)
      REQ_MAC: return bus.mac_ready;
      REQ_ADD: return bus.add_ready;
      default: return bus.drn_ready;
    endcase
  endfunction

  // Raise one request (caller is just after a rising edge), hold it until the
  // accept pulse, drop it after that edge. gcyc reports the grant cycle.
  task automatic req(input req_id_e id, input logic [AL-1:0] a, input logic [W-1:0] d,
                     output int gcyc);
    bit got;
    got  = 0;
    gcyc = -1;
    case (id)
      REQ_MAC: begin bus.mac_addr = a; bus.mac_data = d; bus.mac_valid = 1'b1; end
      REQ_ADD: begin bus.add_addr = a; bus.add_data = d; bus.add_valid = 1'b1; end
      default: begin bus.drn_addr = a; bus.drn_valid = 1'b1; end
    endcase
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ready_of(id)) begin got = 1; gcyc = cyc; end
    end
    if (!got) check("req_timeout", 32'(id), 32'hFFFF);
    @(posedge clk); #1;
    case (id)
      REQ_MAC: bus.mac_valid = 1'b0;
      REQ_ADD: bus.add_valid = 1'b0;
      default: bus.drn_valid = 1'b0;
    endcase
  endtask

  task automatic acc(input req_id_e id, input logic [AL-1:0] a, input logic [W-1:0] d,
                     input logic [W-1:0] expw);
    int g;
    gq.push_back('{id, 0});
    wq.push_back('{a, expw});
    req(id, a, d, g);
  endtask

  task automatic drain(input logic [AL-1:0] a, input logic [W-1:0] expv);
    int g;
    gq.push_back('{REQ_DRN, 0});
    oq.push_back(expv);
    req(REQ_DRN, a, '0, g);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g0, g1, g2;

  initial begin
    bus.mac_valid = 0; bus.mac_addr = '0; bus.mac_data = '0;
    bus.add_valid = 0; bus.add_addr = '0; bus.add_data = '0;
    bus.drn_valid = 0; bus.drn_addr = '0;

    // Reset state, with a request already pending
    #2;
    bus.mac_valid = 1'b1; bus.mac_addr = 4'd7; bus.mac_data = 16'd1;
    #1;
    check("rst_mac_ready", 32'(bus.mac_ready), 32'd0);
    check("rst_sp_addr",   32'(bus.sp_addr),   32'd0);
    check("rst_sp_wen",    32'(bus.sp_wen),    32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    bus.mac_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted in the middle of an ACC_WR
    gq.push_back('{REQ_MAC, 0});
    req(REQ_MAC, 4'd3, 16'd9, g0);
    check("accwr_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_sp_wen",   32'(bus.sp_wen),   32'd0);
    check("midrst_sp_wdata", 32'(bus.sp_wdata), 32'd0);
    check("midrst_sp_addr",  32'(bus.sp_addr),  32'd0);
    check("midrst_busy",     32'(busy),         32'd0);
    @(posedge clk); #1 rst = 1'b0;
    drain(4'd3, 16'd0);

    // Accumulate and drain one entry
    settle();
    acc(REQ_MAC, 4'd3, 16'd5, 16'd5);
    acc(REQ_MAC, 4'd3, 16'd7, 16'd12);
    drain(4'd3, 16'd12);
    drain(4'd3, 16'd0);

    // Modulo wrap on the external path
    acc(REQ_ADD, 4'd5, 16'hFFFF, 16'hFFFF);
    acc(REQ_ADD, 4'd5, 16'd2,    16'h0001);

    // Round-robin with both accumulate requesters held for 8 cycles
    settle();
    gq.push_back('{REQ_MAC, 0}); gq.push_back('{REQ_ADD, 2});
    gq.push_back('{REQ_MAC, 2}); gq.push_back('{REQ_ADD, 2});
    wq.push_back('{4'd8, 16'd1});  wq.push_back('{4'd9, 16'd10});
    wq.push_back('{4'd8, 16'd2});  wq.push_back('{4'd9, 16'd20});
    bus.mac_addr = 4'd8; bus.mac_data = 16'd1;  bus.mac_valid = 1'b1;
    bus.add_addr = 4'd9; bus.add_data = 16'd10; bus.add_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.mac_valid = 1'b0; bus.add_valid = 1'b0;

    // Drain beats both accumulators; MAC follows 2 cycles later, then ADD
    settle();
    gq.push_back('{REQ_DRN, 0}); gq.push_back('{REQ_MAC, 2}); gq.push_back('{REQ_ADD, 2});
    oq.push_back(16'd2);
    wq.push_back('{4'd10, 16'd3}); wq.push_back('{4'd11, 16'd4});
    fork
      req(REQ_DRN, 4'd8,  16'd0, g0);
      req(REQ_MAC, 4'd10, 16'd3, g1);
      req(REQ_ADD, 4'd11, 16'd4, g2);
    join
    check("drn_to_mac_cycles", 32'(g1 - g0), 32'd2);

    // clear in IDLE blocks the grant for that cycle
    settle();
    gq.push_back('{REQ_MAC, 0});
    wq.push_back('{4'd12, 16'd9});
    clear = 1'b1;
    fork
      req(REQ_MAC, 4'd12, 16'd9, g0);
      begin
        @(negedge clk);
        check("clear_blocks_ready", 32'(bus.mac_ready), 32'd0);
        @(posedge clk); #1 clear = 1'b0;
      end
    join

    // clear during ACC_WR on entry 2: write still happens, entry ends invalid
    settle();
    acc(REQ_MAC, 4'd2, 16'd6, 16'd6);
    clear = 1'b1;
    @(negedge clk);
    check("clear_accwr_sp_wen", 32'(bus.sp_wen), 32'd1);
    @(posedge clk); #1 clear = 1'b0;
    check("clear_accwr_idle", 32'(busy), 32'd0);
    drain(4'd2,  16'd0);
    drain(4'd12, 16'd0);

    // clear during DRN_RD suppresses the output strobe
    settle();
    acc(REQ_MAC, 4'd4, 16'd7, 16'd7);
    settle();
    gq.push_back('{REQ_DRN, 0});
    req(REQ_DRN, 4'd4, '0, g0);
    clear = 1'b1;
    @(negedge clk);
    check("clear_drn_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1 clear = 1'b0;
    drain(4'd4, 16'd0);

    settle();
    repeat (3) @(posedge clk);
    #1;
    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("write_queue_empty", 32'(wq.size()), 32'd0);
    check("out_queue_empty",   32'(oq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
